// File: rtl/riscv_axi_arb_pkg.sv
// Shared AXI encodings and sizing helpers for the riscv_axi_arb N-to-1 AXI4 arbiter.
package riscv_axi_arb_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Width of the master index prepended to downstream IDs; at least one bit.
    function automatic int unsigned calc_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/riscv_axi_arb_rr.sv
// Address-channel arbiter: round-robin (or fixed priority with RISCV_AXI_ARB_FIXED_PRIO_EN)
// with a grant lock held from first presentation until the downstream handshake.
module riscv_axi_arb_rr
    import riscv_axi_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = calc_idx_w(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     i_req,
    input  logic             i_en,
    input  logic             i_ready,
    output logic             o_valid_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic [N-1:0]     o_grant_c
);

    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_cand;
    logic             w_hs;

    assign w_hs = o_valid_c & i_en & i_ready;

`ifdef RISCV_AXI_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [IDX_W-1:0] r_ptr;

    assign w_base = r_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (o_idx_c == IDX_W'(N - 1)) ? '0 : o_idx_c + IDX_W'(1);
        end
    end
`endif

    // First requester at or after the base; a held lock overrides the search.
    always_comb begin
        o_valid_c = 1'b0;
        o_idx_c   = '0;
        w_cand    = '0;
        if (r_lock) begin
            o_valid_c = i_req[r_lock_idx];
            o_idx_c   = r_lock_idx;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                w_cand = IDX_W'((32'(w_base) + i) % N);
                if (!o_valid_c && i_req[w_cand]) begin
                    o_valid_c = 1'b1;
                    o_idx_c   = w_cand;
                end
            end
        end
    end

    assign o_grant_c = o_valid_c ? (N'(1) << o_idx_c) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_lock     <= 1'b0;
        end else if (o_valid_c && i_en) begin
            r_lock     <= 1'b1;
            r_lock_idx <= o_idx_c;
        end
    end

endmodule

// File: rtl/riscv_axi_arb.sv
// N-to-1 AXI4 arbiter: independent AR/AW arbitration, W ordered by an owner FIFO,
// R/B routed by master index in the upper ID bits. Option: RISCV_AXI_ARB_FIXED_PRIO_EN.
module riscv_axi_arb
    import riscv_axi_arb_pkg::*;
#(
    parameter  int unsigned NUM_M         = 2,
    parameter  int unsigned ID_W          = 4,
    parameter  int unsigned ADDR_W        = 32,
    parameter  int unsigned DATA_W        = 32,
    parameter  int unsigned WR_FIFO_DEPTH = 4,
    localparam int unsigned IDX_W         = calc_idx_w(NUM_M),
    localparam int unsigned STRB_W        = DATA_W / 8,
    localparam int unsigned MID_W         = ID_W + IDX_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_M-1:0]         s_axi_awvalid_i,
    input  logic [NUM_M*ADDR_W-1:0]  s_axi_awaddr_i,
    input  logic [NUM_M*ID_W-1:0]    s_axi_awid_i,
    input  logic [NUM_M*8-1:0]       s_axi_awlen_i,
    input  logic [NUM_M*2-1:0]       s_axi_awburst_i,
    output logic [NUM_M-1:0]         s_axi_awready_o,
    input  logic [NUM_M-1:0]         s_axi_wvalid_i,
    input  logic [NUM_M*DATA_W-1:0]  s_axi_wdata_i,
    input  logic [NUM_M*STRB_W-1:0]  s_axi_wstrb_i,
    input  logic [NUM_M-1:0]         s_axi_wlast_i,
    output logic [NUM_M-1:0]         s_axi_wready_o,
    output logic [NUM_M-1:0]         s_axi_bvalid_o,
    output logic [NUM_M*2-1:0]       s_axi_bresp_o,
    output logic [NUM_M*ID_W-1:0]    s_axi_bid_o,
    input  logic [NUM_M-1:0]         s_axi_bready_i,
    input  logic [NUM_M-1:0]         s_axi_arvalid_i,
    input  logic [NUM_M*ADDR_W-1:0]  s_axi_araddr_i,
    input  logic [NUM_M*ID_W-1:0]    s_axi_arid_i,
    input  logic [NUM_M*8-1:0]       s_axi_arlen_i,
    input  logic [NUM_M*2-1:0]       s_axi_arburst_i,
    output logic [NUM_M-1:0]         s_axi_arready_o,
    output logic [NUM_M-1:0]         s_axi_rvalid_o,
    output logic [NUM_M*DATA_W-1:0]  s_axi_rdata_o,
    output logic [NUM_M*2-1:0]       s_axi_rresp_o,
    output logic [NUM_M*ID_W-1:0]    s_axi_rid_o,
    output logic [NUM_M-1:0]         s_axi_rlast_o,
    input  logic [NUM_M-1:0]         s_axi_rready_i,
    output logic                     m_axi_awvalid_o,
    output logic [ADDR_W-1:0]        m_axi_awaddr_o,
    output logic [MID_W-1:0]         m_axi_awid_o,
    output logic [7:0]               m_axi_awlen_o,
    output logic [1:0]               m_axi_awburst_o,
    input  logic                     m_axi_awready_i,
    output logic                     m_axi_wvalid_o,
    output logic [DATA_W-1:0]        m_axi_wdata_o,
    output logic [STRB_W-1:0]        m_axi_wstrb_o,
    output logic                     m_axi_wlast_o,
    input  logic                     m_axi_wready_i,
    input  logic                     m_axi_bvalid_i,
    input  logic [1:0]               m_axi_bresp_i,
    input  logic [MID_W-1:0]         m_axi_bid_i,
    output logic                     m_axi_bready_o,
    output logic                     m_axi_arvalid_o,
    output logic [ADDR_W-1:0]        m_axi_araddr_o,
    output logic [MID_W-1:0]         m_axi_arid_o,
    output logic [7:0]               m_axi_arlen_o,
    output logic [1:0]               m_axi_arburst_o,
    input  logic                     m_axi_arready_i,
    input  logic                     m_axi_rvalid_i,
    input  logic [DATA_W-1:0]        m_axi_rdata_i,
    input  logic [1:0]               m_axi_rresp_i,
    input  logic [MID_W-1:0]         m_axi_rid_i,
    input  logic                     m_axi_rlast_i,
    output logic                     m_axi_rready_o
);

    localparam int unsigned PTR_W = (WR_FIFO_DEPTH <= 2) ? 1 : $clog2(WR_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(WR_FIFO_DEPTH + 1);

    logic             w_ar_valid;
    logic [IDX_W-1:0] w_ar_idx;
    logic [NUM_M-1:0] w_ar_grant;
    logic             w_aw_valid;
    logic [IDX_W-1:0] w_aw_idx;
    logic [NUM_M-1:0] w_aw_grant;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_w_head;
    logic [IDX_W-1:0] w_r_idx;
    logic [IDX_W-1:0] w_b_idx;
    logic [NUM_M-1:0] w_r_onehot;
    logic [NUM_M-1:0] w_b_onehot;
    logic             w_r_known;
    logic             w_b_known;

    logic [IDX_W-1:0] r_mem [WR_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    riscv_axi_arb_rr #(.N(NUM_M), .IDX_W(IDX_W)) u_ar_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     (s_axi_arvalid_i),
        .i_en      (1'b1),
        .i_ready   (m_axi_arready_i),
        .o_valid_c (w_ar_valid),
        .o_idx_c   (w_ar_idx),
        .o_grant_c (w_ar_grant)
    );

    // AW may only be presented while the owner FIFO has room.
    riscv_axi_arb_rr #(.N(NUM_M), .IDX_W(IDX_W)) u_aw_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_req     (s_axi_awvalid_i),
        .i_en      (~w_fifo_full),
        .i_ready   (m_axi_awready_i),
        .o_valid_c (w_aw_valid),
        .o_idx_c   (w_aw_idx),
        .o_grant_c (w_aw_grant)
    );

    assign m_axi_arvalid_o = w_ar_valid & ~rst_i;
    assign m_axi_araddr_o  = s_axi_araddr_i[32'(w_ar_idx)*ADDR_W +: ADDR_W];
    assign m_axi_arid_o    = {w_ar_idx, s_axi_arid_i[32'(w_ar_idx)*ID_W +: ID_W]};
    assign m_axi_arlen_o   = s_axi_arlen_i[32'(w_ar_idx)*8 +: 8];
    assign m_axi_arburst_o = s_axi_arburst_i[32'(w_ar_idx)*2 +: 2];
    assign s_axi_arready_o = w_ar_grant & {NUM_M{m_axi_arready_i & ~rst_i}};

    assign m_axi_awvalid_o = w_aw_valid & ~w_fifo_full & ~rst_i;
    assign m_axi_awaddr_o  = s_axi_awaddr_i[32'(w_aw_idx)*ADDR_W +: ADDR_W];
    assign m_axi_awid_o    = {w_aw_idx, s_axi_awid_i[32'(w_aw_idx)*ID_W +: ID_W]};
    assign m_axi_awlen_o   = s_axi_awlen_i[32'(w_aw_idx)*8 +: 8];
    assign m_axi_awburst_o = s_axi_awburst_i[32'(w_aw_idx)*2 +: 2];
    assign s_axi_awready_o = w_aw_grant & {NUM_M{m_axi_awready_i & ~w_fifo_full & ~rst_i}};

    assign w_push       = m_axi_awvalid_o & m_axi_awready_i;
    assign w_pop        = m_axi_wvalid_o & m_axi_wready_i & m_axi_wlast_o;
    assign w_fifo_full  = (r_cnt == CNT_W'(WR_FIFO_DEPTH));
    assign w_fifo_empty = (r_cnt == '0);
    assign w_w_head     = r_mem[r_rptr];

    // W-owner FIFO: one entry per accepted AW, retired by that burst's last beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= w_aw_idx;
    end

    assign m_axi_wvalid_o = ~rst_i & ~w_fifo_empty & s_axi_wvalid_i[w_w_head];
    assign m_axi_wdata_o  = s_axi_wdata_i[32'(w_w_head)*DATA_W +: DATA_W];
    assign m_axi_wstrb_o  = s_axi_wstrb_i[32'(w_w_head)*STRB_W +: STRB_W];
    assign m_axi_wlast_o  = s_axi_wlast_i[w_w_head];
    assign s_axi_wready_o = (~rst_i & ~w_fifo_empty & m_axi_wready_i) ? (NUM_M'(1) << w_w_head) : '0;

    // Responses: upper ID bits select the master; unknown indices are drained and dropped.
    assign w_r_idx    = m_axi_rid_i[MID_W-1 -: IDX_W];
    assign w_r_known  = (32'(w_r_idx) < NUM_M);
    assign w_r_onehot = w_r_known ? (NUM_M'(1) << w_r_idx) : '0;

    assign s_axi_rvalid_o = (m_axi_rvalid_i & ~rst_i) ? w_r_onehot : '0;
    assign s_axi_rdata_o  = {NUM_M{m_axi_rdata_i}};
    assign s_axi_rresp_o  = {NUM_M{m_axi_rresp_i}};
    assign s_axi_rid_o    = {NUM_M{m_axi_rid_i[ID_W-1:0]}};
    assign s_axi_rlast_o  = {NUM_M{m_axi_rlast_i}};
    assign m_axi_rready_o = ~rst_i & (w_r_known ? |(s_axi_rready_i & w_r_onehot) : 1'b1);

    assign w_b_idx    = m_axi_bid_i[MID_W-1 -: IDX_W];
    assign w_b_known  = (32'(w_b_idx) < NUM_M);
    assign w_b_onehot = w_b_known ? (NUM_M'(1) << w_b_idx) : '0;

    assign s_axi_bvalid_o = (m_axi_bvalid_i & ~rst_i) ? w_b_onehot : '0;
    assign s_axi_bresp_o  = {NUM_M{m_axi_bresp_i}};
    assign s_axi_bid_o    = {NUM_M{m_axi_bid_i[ID_W-1:0]}};
    assign m_axi_bready_o = ~rst_i & (w_b_known ? |(s_axi_bready_i & w_b_onehot) : 1'b1);

endmodule

// File: tb/tb_riscv_axi_arb.sv
// Scoreboard bench for riscv_axi_arb with NUM_M=2: directed stimulus, expected handshakes queued,
// a negedge monitor pops and compares every downstream/upstream handshake.
module tb_riscv_axi_arb;

    localparam int unsigned NUM_M = 2;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned MID_W = 5;

    logic        clk;
    logic        rst;

    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
    logic [63:0] s_awaddr, s_wdata;
    logic [7:0]  s_awid, s_wstrb;
    logic [15:0] s_awlen;
    logic [3:0]  s_awburst;
    logic [1:0]  s_bvalid, s_bready;
    logic [3:0]  s_bresp;
    logic [7:0]  s_bid;
    logic [1:0]  s_arvalid, s_arready;
    logic [63:0] s_araddr;
    logic [7:0]  s_arid;
    logic [15:0] s_arlen;
    logic [3:0]  s_arburst;
    logic [1:0]  s_rvalid, s_rlast, s_rready;
    logic [63:0] s_rdata;
    logic [3:0]  s_rresp;
    logic [7:0]  s_rid;

    logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
    logic [31:0] m_awaddr, m_wdata;
    logic [4:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [1:0]  m_awburst;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic [4:0]  m_bid;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [4:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [1:0]  m_arburst;
    logic        m_rvalid, m_rlast, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [4:0]  m_rid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [46:0] ar_q[$];
    logic [46:0] aw_q[$];
    logic [36:0] w_q[$];
    logic [39:0] r_q[$];
    logic [6:0]  b_q[$];

    riscv_axi_arb #(
        .NUM_M(2), .ID_W(4), .ADDR_W(32), .DATA_W(32), .WR_FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awvalid_i(s_awvalid), .s_axi_awaddr_i(s_awaddr), .s_axi_awid_i(s_awid),
        .s_axi_awlen_i(s_awlen), .s_axi_awburst_i(s_awburst), .s_axi_awready_o(s_awready),
        .s_axi_wvalid_i(s_wvalid), .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb),
        .s_axi_wlast_i(s_wlast), .s_axi_wready_o(s_wready),
        .s_axi_bvalid_o(s_bvalid), .s_axi_bresp_o(s_bresp), .s_axi_bid_o(s_bid), .s_axi_bready_i(s_bready),
        .s_axi_arvalid_i(s_arvalid), .s_axi_araddr_i(s_araddr), .s_axi_arid_i(s_arid),
        .s_axi_arlen_i(s_arlen), .s_axi_arburst_i(s_arburst), .s_axi_arready_o(s_arready),
        .s_axi_rvalid_o(s_rvalid), .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp),
        .s_axi_rid_o(s_rid), .s_axi_rlast_o(s_rlast), .s_axi_rready_i(s_rready),
        .m_axi_awvalid_o(m_awvalid), .m_axi_awaddr_o(m_awaddr), .m_axi_awid_o(m_awid),
        .m_axi_awlen_o(m_awlen), .m_axi_awburst_o(m_awburst), .m_axi_awready_i(m_awready),
        .m_axi_wvalid_o(m_wvalid), .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb),
        .m_axi_wlast_o(m_wlast), .m_axi_wready_i(m_wready),
        .m_axi_bvalid_i(m_bvalid), .m_axi_bresp_i(m_bresp), .m_axi_bid_i(m_bid), .m_axi_bready_o(m_bready),
        .m_axi_arvalid_o(m_arvalid), .m_axi_araddr_o(m_araddr), .m_axi_arid_o(m_arid),
        .m_axi_arlen_o(m_arlen), .m_axi_arburst_o(m_arburst), .m_axi_arready_i(m_arready),
        .m_axi_rvalid_i(m_rvalid), .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp),
        .m_axi_rid_i(m_rid), .m_axi_rlast_i(m_rlast), .m_axi_rready_o(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input int k, input logic v, input logic [31:0] a, input logic [3:0] id);
        s_arvalid[k] = v;
        s_araddr[k*32 +: 32] = a;
        s_arid[k*4 +: 4] = id;
        s_arlen[k*8 +: 8] = 8'd0;
        s_arburst[k*2 +: 2] = 2'b01;
    endtask

    task automatic set_aw(input int k, input logic v, input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len);
        s_awvalid[k] = v;
        s_awaddr[k*32 +: 32] = a;
        s_awid[k*4 +: 4] = id;
        s_awlen[k*8 +: 8] = len;
        s_awburst[k*2 +: 2] = 2'b01;
    endtask

    task automatic set_w(input int k, input logic v, input logic [31:0] d, input logic last);
        s_wvalid[k] = v;
        s_wdata[k*32 +: 32] = d;
        s_wstrb[k*4 +: 4] = 4'hF;
        s_wlast[k] = last;
    endtask

    task automatic check_idle(input string name);
        check(name, {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                     s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 64'd0);
    endtask

    // Monitor: every handshake pops the oldest expectation of its channel.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_arvalid && m_arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                else check("ar_hs", {m_arid, m_araddr, m_arlen, m_arburst}, ar_q.pop_front());
            end
            if (m_awvalid && m_awready) begin
                if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("aw_hs", {m_awid, m_awaddr, m_awlen, m_awburst}, aw_q.pop_front());
            end
            if (m_wvalid && m_wready) begin
                if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else check("w_hs", {m_wdata, m_wstrb, m_wlast}, w_q.pop_front());
            end
            for (int k = 0; k < NUM_M; k++) begin
                if (s_rvalid[k] && s_rready[k]) begin
                    if (r_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
                    else check("r_hs", {1'(k), s_rid[k*ID_W +: ID_W], s_rdata[k*32 +: 32],
                                        s_rresp[k*2 +: 2], s_rlast[k]}, r_q.pop_front());
                end
                if (s_bvalid[k] && s_bready[k]) begin
                    if (b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                    else check("b_hs", {1'(k), s_bid[k*ID_W +: ID_W], s_bresp[k*2 +: 2]}, b_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awburst = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
        s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arburst = '0;
        s_bready = 2'b11; s_rready = 2'b11;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b1; m_bresp = 2'b00; m_bid = 5'h00;
        m_rvalid = 1'b1; m_rdata = '0; m_rresp = 2'b00; m_rid = 5'h00; m_rlast = 1'b1;
        set_ar(0, 1'b1, 32'h100, 4'h1);
        set_aw(1, 1'b1, 32'h200, 4'h2, 8'd0);

        // Reset: every valid/ready output must be low despite active inputs.
        step;
        @(negedge clk);
        check_idle("reset_idle");
        step;
        rst = 1'b0;
        set_ar(0, 1'b0, 32'h0, 4'h0);
        set_aw(1, 1'b0, 32'h0, 4'h0, 8'd0);
        m_bvalid = 1'b0;
        m_rvalid = 1'b0;

        // T1: simultaneous AR, round-robin m0 then m1, twice (pointer wraps to 0).
        for (int r = 0; r < 2; r++) begin
            ar_q.push_back({5'h03, 32'h1000 + 32'(r*4), 8'd0, 2'b01});
            ar_q.push_back({5'h15, 32'h2000 + 32'(r*4), 8'd0, 2'b01});
            set_ar(0, 1'b1, 32'h1000 + 32'(r*4), 4'h3);
            set_ar(1, 1'b1, 32'h2000 + 32'(r*4), 4'h5);
            @(negedge clk);
            check("ar_rr_first_m0", {62'd0, s_arready}, 64'd1);
            step;
            set_ar(0, 1'b0, 32'h0, 4'h0);
            @(negedge clk);
            check("ar_rr_second_m1", {62'd0, s_arready}, 64'd2);
            step;
            set_ar(1, 1'b0, 32'h0, 4'h0);
        end

        // T2: m1 held under back-pressure; later m0 request must not steal the grant.
        m_arready = 1'b0;
        ar_q.push_back({5'h16, 32'h3000, 8'd0, 2'b01});
        ar_q.push_back({5'h02, 32'h3100, 8'd0, 2'b01});
        set_ar(1, 1'b1, 32'h3000, 4'h6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ar_hold_m1", {58'd0, m_arvalid, m_arid}, {58'd0, 1'b1, 5'h16});
            step;
        end
        set_ar(0, 1'b1, 32'h3100, 4'h2);
        @(negedge clk);
        check("ar_lock_stable", {50'd0, m_arid, m_araddr[7:0], s_arready}, {50'd0, 5'h16, 8'h00, 2'b00});
        step;
        m_arready = 1'b1;
        @(negedge clk);
        check("ar_lock_hs_m1", {62'd0, s_arready}, 64'd2);
        step;
        set_ar(1, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        check("ar_next_m0", {62'd0, s_arready}, 64'd1);
        step;
        set_ar(0, 1'b0, 32'h0, 4'h0);

        // T3: W ordering follows AW order; m1's early W waits behind m0's 4-beat burst.
        aw_q.push_back({5'h01, 32'h4000, 8'd3, 2'b01});
        aw_q.push_back({5'h17, 32'h5000, 8'd0, 2'b01});
        for (int i = 0; i < 4; i++) w_q.push_back({32'hA0 + 32'(i), 4'hF, (i == 3)});
        w_q.push_back({32'hB0, 4'hF, 1'b1});
        set_aw(0, 1'b1, 32'h4000, 4'h1, 8'd3);
        set_aw(1, 1'b1, 32'h5000, 4'h7, 8'd0);
        set_w(1, 1'b1, 32'hB0, 1'b1);
        @(negedge clk);
        check("w_fifo_empty_block", {61'd0, m_wvalid, s_wready}, 64'd0);
        check("aw_first_m0", {62'd0, s_awready}, 64'd1);
        step;
        set_aw(0, 1'b0, 32'h0, 4'h0, 8'd0);
        @(negedge clk);
        check("w_head_m0", {62'd0, s_wready}, 64'd1);
        check("aw_second_m1", {62'd0, s_awready}, 64'd2);
        step;
        set_aw(1, 1'b0, 32'h0, 4'h0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            set_w(0, 1'b1, 32'hA0 + 32'(i), (i == 3));
            @(negedge clk);
            check("w_m1_blocked", {63'd0, s_wready[1]}, 64'd0);
            step;
        end
        set_w(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("w_m1_pass", {62'd0, s_wready}, 64'd2);
        step;
        set_w(1, 1'b0, 32'h0, 1'b0);

        // T4: four AWs fill the owner FIFO; the fifth stalls, including on the pop cycle.
        for (int i = 0; i < 4; i++) begin
            aw_q.push_back({5'h02, 32'h6000 + 32'(i*16), 8'd0, 2'b01});
            set_aw(0, 1'b1, 32'h6000 + 32'(i*16), 4'h2, 8'd0);
            @(negedge clk);
            check("aw_fill", {63'd0, s_awready[0]}, 64'd1);
            step;
        end
        aw_q.push_back({5'h02, 32'h6040, 8'd0, 2'b01});
        set_aw(0, 1'b1, 32'h6040, 4'h2, 8'd0);
        @(negedge clk);
        check("aw_full_stall", {62'd0, s_awready[0], m_awvalid}, 64'd0);
        step;
        w_q.push_back({32'hC0, 4'hF, 1'b1});
        set_w(0, 1'b1, 32'hC0, 1'b1);
        @(negedge clk);
        check("aw_full_pop_stall", {62'd0, s_awready[0], s_wready[0]}, 64'd1);
        step;
        set_w(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("aw_after_pop", {63'd0, s_awready[0]}, 64'd1);
        step;
        set_aw(0, 1'b0, 32'h0, 4'h0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            w_q.push_back({32'hC1 + 32'(i), 4'hF, 1'b1});
            set_w(0, 1'b1, 32'hC1 + 32'(i), 1'b1);
            step;
        end
        set_w(0, 1'b0, 32'h0, 1'b0);

        // T5: R/B routing by upper ID bit, back-pressure from the selected master.
        s_rready = 2'b01;
        r_q.push_back({1'b1, 4'h3, 32'hDEAD0001, 2'b00, 1'b1});
        m_rvalid = 1'b1; m_rid = 5'b1_0011; m_rdata = 32'hDEAD0001; m_rresp = 2'b00; m_rlast = 1'b1;
        @(negedge clk);
        check("r_route", {58'd0, s_rvalid, s_rid[7:4]}, {58'd0, 2'b10, 4'h3});
        check("r_backpressure", {63'd0, m_rready}, 64'd0);
        step;
        s_rready = 2'b11;
        @(negedge clk);
        check("r_ready", {63'd0, m_rready}, 64'd1);
        step;
        m_rvalid = 1'b0;
        b_q.push_back({1'b0, 4'h2, 2'b10});
        m_bvalid = 1'b1; m_bid = 5'b0_0010; m_bresp = 2'b10;
        @(negedge clk);
        check("b_route", {61'd0, s_bvalid, m_bready}, {61'd0, 2'b01, 1'b1});
        step;
        m_bvalid = 1'b0;

        // T6: reset mid-burst clears the FIFO and the AR pointer (currently pointing at m1).
        aw_q.push_back({5'h04, 32'h7000, 8'd3, 2'b01});
        set_aw(0, 1'b1, 32'h7000, 4'h4, 8'd3);
        step;
        set_aw(0, 1'b0, 32'h0, 4'h0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            w_q.push_back({32'hE0 + 32'(i), 4'hF, 1'b0});
            set_w(0, 1'b1, 32'hE0 + 32'(i), 1'b0);
            step;
        end
        set_w(0, 1'b1, 32'hE2, 1'b0);
        rst = 1'b1;
        m_rvalid = 1'b1;
        m_bvalid = 1'b1;
        set_ar(0, 1'b1, 32'h8100, 4'h1);
        set_ar(1, 1'b1, 32'h8000, 4'h9);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_idle("reset_mid_burst");
            step;
        end
        rst = 1'b0;
        m_rvalid = 1'b0;
        m_bvalid = 1'b0;
        ar_q.push_back({5'h01, 32'h8100, 8'd0, 2'b01});
        ar_q.push_back({5'h19, 32'h8000, 8'd0, 2'b01});
        @(negedge clk);
        check("fifo_empty_after_rst", {61'd0, m_wvalid, s_wready}, 64'd0);
        check("ar_m0_after_rst", {62'd0, s_arready}, 64'd1);
        step;
        set_ar(0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        check("ar_m1_after_rst", {62'd0, s_arready}, 64'd2);
        step;
        set_ar(1, 1'b0, 32'h0, 4'h0);
        set_w(0, 1'b0, 32'h0, 1'b0);

        repeat (2) step;
        check("scoreboard_drained",
              64'(ar_q.size() + aw_q.size() + w_q.size() + r_q.size() + b_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_axi_arb.md
# riscv_axi_arb

N-to-1 AXI4 arbiter merging the per-agent instruction/data cache AXI masters into one shared memory port. It sits between the `icache`, `dcache` and any further caches of a multi-core build and the single system bus. AR and AW are arbitrated independently. Responses are routed back by a master index prepended to the transaction ID. Write data is ordered by a small owner FIFO.

## Interface
Parameters:
- NUM_M, 2, number of upstream masters (2..8)
- ID_W, 4, upstream AXI ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe = DATA_W/8)
- WR_FIFO_DEPTH, 4, outstanding AW-without-completed-W entries (power of 2)
- IDX_W (localparam), max(1,clog2(NUM_M)); downstream ID width = ID_W+IDX_W

Ports (upstream buses flattened, master k in slice k):
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- s_axi_aw{valid,addr,id,len,burst}_i  in  NUM_M×{1,ADDR_W,ID_W,8,2}  upstream write address
- s_axi_awready_o  out  NUM_M  upstream AW accept
- s_axi_w{valid,data,strb,last}_i  in  NUM_M×{1,DATA_W,DATA_W/8,1}  upstream write data
- s_axi_wready_o  out  NUM_M  upstream W accept
- s_axi_b{valid,resp,id}_o  out  NUM_M×{1,2,ID_W}  upstream write response
- s_axi_bready_i  in  NUM_M  upstream B accept
- s_axi_ar{valid,addr,id,len,burst}_i  in  NUM_M×{1,ADDR_W,ID_W,8,2}  upstream read address
- s_axi_arready_o  out  NUM_M  upstream AR accept
- s_axi_r{valid,data,resp,id,last}_o  out  NUM_M×{1,DATA_W,2,ID_W,1}  upstream read data
- s_axi_rready_i  in  NUM_M  upstream R accept
- m_axi_aw*/w*/ar*, m_axi_bready_o/rready_o  out  same fields, single, ID width ID_W+IDX_W  downstream requests
- m_axi_awready_i/wready_i/arready_i, m_axi_b*/r*  in  same fields, single  downstream responses

## Operation
- Reset: grant pointers = 0, locks clear, FIFO empty. While rst_i=1 every valid/ready output is forced 0.
- AR/AW arbitration (independent, same logic): with no lock, pick the requesting master at or after the pointer (round-robin). The winner drives m_axi_ar*. m_axi_arid = {idx, s_arid}. If m_arready=0, latch lock=winner; the grant is held until handshake (AXI stability, no re-arbitration). On handshake, pointer = winner+1 mod NUM_M and lock clears. Non-granted s_arready = 0.
- AW additionally requires FIFO not full. On AW handshake, push winner idx into the W-owner FIFO.
- W: when FIFO not empty, m_axi_w* = head master's W. s_wready[head] = m_wready, all others 0. Pop on handshake with wlast=1.
- FIFO full and simultaneous pop: AW is still stalled that cycle (no pop credit).
- R/B routing: idx = upper IDX_W bits of rid/bid. Assert s_rvalid[idx] with the stripped lower ID_W bits. m_rready = s_rready[idx]. An idx ≥ NUM_M is absorbed (ready=1) and dropped.
- Multiple outstanding reads and writes per master are allowed. Ordering is per-ID only.
- A master presenting W before its AW is accepted waits (wready=0). Upstream caches issue AW no later than W.

## Timing
- AR/AW/W/R/B paths are combinational: zero added latency, single-cycle handshakes.
- Lock/pointer/FIFO update at the clock edge of the handshake.
- A W beat for a newly accepted AW is forwardable at the earliest in the cycle after the AW handshake (empty FIFO, registered head).
- Round-robin fairness: a continuously requesting master is granted within NUM_M handshakes.

## Configuration
- RISCV_AXI_ARB_FIXED_PRIO_EN defined: AR/AW use fixed priority, lowest index wins, and pointers are not implemented. Lock/hold behaviour is unchanged.
- Not defined: round-robin as above.

## Structure
- Package riscv_axi_arb_pkg: AXI burst encodings (INCR=2'b01), response codes (OKAY/SLVERR), IDX_W computation function.
- One sub-module: riscv_axi_arb_rr (request vector, handshake, lock/pointer state, one-hot grant), instantiated for AR and AW.
- The W-owner FIFO is inline.

## Test plan
- NUM_M=2, both arvalid in the same cycle, arready=1: grants m0 then m1. Downstream arid = {0,id} then {1,id}. Pointer returns to 0.
- m1 arvalid with arready=0 for 3 cycles, then m0 also requests: m1 is held stable until handshake. m0 is granted next.
- AW m0 (len=3) then AW m1 (len=0), W from m1 presented first: m1 wready=0 until m0's 4th beat with wlast. Then m1's beat passes.
- 4 AWs with no W (WR_FIFO_DEPTH=4): 5th AW gets awready=0. One wlast pop frees it the following cycle.
- rid=5'b1_0011 and bid=5'b0_0010: s_rvalid[1] with rid 3, s_bvalid[0] with bid 2. Back-pressure via s_rready[1]=0 propagates to m_rready=0.
- Reset asserted mid-burst (after 2 of 4 W beats): all valid/ready outputs 0 during reset. After release the FIFO is empty, pointer is 0 and the next AR grants m0.
